sobel_stream_param: RTL and testbench

//  Parametrised, mode-selectable streaming 3x3 Sobel engine; successor to the fixed 320x240 ROM-fed filter.

---
 rtl/sobel_pkg.sv | 26 ++
 rtl/sobel_line_buffer.sv | 27 ++
 rtl/sobel_stream_param.sv | 217 +++++++++++++++++++++
 tb/tb_sobel_stream_param.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared constants and width helpers for the streaming Sobel engine.
// Mode encodings are fixed per frame and sampled on SOF.
package sobel_pkg;

  localparam logic [2:0] MODE_MAG     = 3'd0;
  localparam logic [2:0] MODE_GX_ABS  = 3'd1;
  localparam logic [2:0] MODE_GY_ABS  = 3'd2;
  localparam logic [2:0] MODE_THRESH  = 3'd3;
  localparam logic [2:0] MODE_ORIG    = 3'd4;
  localparam logic [2:0] MODE_OVERLAY = 3'd5;

  localparam int LATENCY = 4;

  function automatic int grad_w(input int pix_w);
    return pix_w + 3;
  endfunction

  function automatic int abs_w(input int pix_w);
    return pix_w + 2;
  endfunction

  function automatic int mag_w(input int pix_w);
    return pix_w + 3;
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// Single-port read-first line store, one-cycle registered read.
// Contents are deliberately not reset.
module sobel_line_buffer #(
  parameter int DEPTH = 320,
  parameter int W     = 8
)(
  input  logic                     clk,
  input  logic                     en_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [W-1:0]             wdata_i,
  output logic [W-1:0]             rdata_o
);

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q;

  // read returns the word stored before this cycle's write
  always_ff @(posedge clk) begin
    if (en_i) begin
      rdata_q      <= mem[addr_i];
      mem[addr_i]  <= wdata_i;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sobel_stream_param.sv
// Streaming 3x3 Sobel with per-frame output mode.
// Four-cycle latency, one result per accepted beat.
module sobel_stream_param
  import sobel_pkg::*;
#(
  parameter int IMG_W     = 320,
  parameter int IMG_H     = 240,
  parameter int PIX_W     = 8,
  parameter int MAG_SHIFT = 0
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [PIX_W-1:0] in_pix,
  input  logic [2:0]       mode,
  input  logic [PIX_W-1:0] thresh,
  output logic             out_valid,
  output logic             out_sof,
  output logic [PIX_W-1:0] out_pix,
  output logic [PIX_W-1:0] out_orig,
  output logic             out_border
);

  localparam int XW   = $clog2(IMG_W);
  localparam int YW   = $clog2(IMG_H);
  localparam int GW   = grad_w(PIX_W);
  localparam int AW   = abs_w(PIX_W);
  localparam int MW   = mag_w(PIX_W);
  localparam int L    = LATENCY;
  localparam int PMAX = (1 << PIX_W) - 1;

  logic [XW-1:0]    x_q, x_d, px;
  logic [YW-1:0]    y_q, y_d, py;
  logic [2:0]       mode_q, mode_d;
  logic [PIX_W-1:0] thr_q, thr_d;
  logic             beat;

  logic [L-1:0]     vld_q, sof_q, bd_q;
  logic [2:0]       md_q [L-1];
  logic [PIX_W-1:0] th_q [L-1];

  logic [XW-1:0]    a0_q;
  logic [PIX_W-1:0] p0_q, p1_q, r1_q;
  logic [PIX_W-1:0] lb1_rd, lb0_rd;
  logic [PIX_W-1:0] win_q [3][3];

  logic signed [GW-1:0] gx_c, gy_c;
  logic [AW-1:0]        ax_c, ay_c;
  logic [MW-1:0]        sum_c, mag_c;
  logic [PIX_W-1:0]     magc_c, pix_d;
  logic [PIX_W-1:0]     out_pix_q, out_orig_q;

  function automatic logic signed [GW-1:0] ext(
    input logic [PIX_W-1:0] p
  );
    return $signed({3'b000, p});
  endfunction

  function automatic logic [PIX_W-1:0] sat(
    input logic [MW-1:0] v
  );
    if (v > MW'(PMAX)) return '1;
    return v[PIX_W-1:0];
  endfunction

  assign beat = in_valid && rst_n;
  assign px   = in_sof ? '0 : x_q;
  assign py   = in_sof ? '0 : y_q;

  // raster position and per-frame settings for the next beat
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    mode_d = mode_q;
    thr_d  = thr_q;
    if (in_valid) begin
      if (in_sof) begin
        mode_d = mode;
        thr_d  = thresh;
      end
      if (px == XW'(IMG_W - 1)) begin
        x_d = '0;
        y_d = (py == YW'(IMG_H - 1)) ? '0 : py + 1'b1;
      end else begin
        x_d = px + 1'b1;
        y_d = py;
      end
    end
  end

  // counters, settings and beat-aligned control shift registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q    <= '0;
      y_q    <= '0;
      mode_q <= MODE_MAG;
      thr_q  <= '0;
      vld_q  <= '0;
      sof_q  <= '0;
      bd_q   <= '0;
      for (int i = 0; i < L-1; i++) begin
        md_q[i] <= MODE_MAG;
        th_q[i] <= '0;
      end
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      mode_q <= mode_d;
      thr_q  <= thr_d;
      vld_q  <= {vld_q[L-2:0], in_valid};
      sof_q  <= {sof_q[L-2:0], in_valid & in_sof};
      bd_q   <= {bd_q[L-2:0],
                 in_valid & ((px < XW'(2)) | (py < YW'(2)))};
      md_q[0] <= mode_d;
      th_q[0] <= thr_d;
      for (int i = 1; i < L-1; i++) begin
        md_q[i] <= md_q[i-1];
        th_q[i] <= th_q[i-1];
      end
    end
  end

  sobel_line_buffer #(.DEPTH(IMG_W), .W(PIX_W)) u_lb1 (
    .clk     (clk),
    .en_i    (beat),
    .addr_i  (px),
    .wdata_i (in_pix),
    .rdata_o (lb1_rd)
  );

  // LB0 trails LB1 by a cycle so it can take LB1's old word
  sobel_line_buffer #(.DEPTH(IMG_W), .W(PIX_W)) u_lb0 (
    .clk     (clk),
    .en_i    (vld_q[0]),
    .addr_i  (a0_q),
    .wdata_i (lb1_rd),
    .rdata_o (lb0_rd)
  );

  // align rows and shift the window one column per beat
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a0_q <= '0;
      p0_q <= '0;
      p1_q <= '0;
      r1_q <= '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win_q[r][c] <= '0;
    end else begin
      if (in_valid) begin
        a0_q <= px;
        p0_q <= in_pix;
      end
      if (vld_q[0]) begin
        p1_q <= p0_q;
        r1_q <= lb1_rd;
      end
      if (vld_q[1]) begin
        for (int r = 0; r < 3; r++) begin
          win_q[r][0] <= win_q[r][1];
          win_q[r][1] <= win_q[r][2];
        end
        win_q[0][2] <= lb0_rd;
        win_q[1][2] <= r1_q;
        win_q[2][2] <= p1_q;
      end
    end
  end

  // gradients, magnitude and mode selection
  always_comb begin
    gx_c = (ext(win_q[0][2]) + (ext(win_q[1][2]) <<< 1)
          + ext(win_q[2][2]))
         - (ext(win_q[0][0]) + (ext(win_q[1][0]) <<< 1)
          + ext(win_q[2][0]));
    gy_c = (ext(win_q[0][0]) + (ext(win_q[0][1]) <<< 1)
          + ext(win_q[0][2]))
         - (ext(win_q[2][0]) + (ext(win_q[2][1]) <<< 1)
          + ext(win_q[2][2]));
    ax_c   = gx_c[GW-1] ? AW'(-gx_c) : AW'(gx_c);
    ay_c   = gy_c[GW-1] ? AW'(-gy_c) : AW'(gy_c);
    sum_c  = MW'(ax_c) + MW'(ay_c);
    mag_c  = sum_c >> MAG_SHIFT;
    magc_c = sat(mag_c);
    case (md_q[L-2])
      MODE_GX_ABS:  pix_d = sat(MW'(ax_c));
      MODE_GY_ABS:  pix_d = sat(MW'(ay_c));
      MODE_THRESH:  pix_d = (mag_c >= MW'(th_q[L-2])) ? '1 : '0;
      MODE_ORIG:    pix_d = win_q[1][1];
      MODE_OVERLAY: pix_d = (win_q[1][1] > magc_c)
                            ? win_q[1][1] : magc_c;
      default:      pix_d = magc_c;
    endcase
    if (bd_q[L-2])
      pix_d = (md_q[L-2] == MODE_ORIG) ? win_q[1][1] : '0;
  end

  // registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_pix_q  <= '0;
      out_orig_q <= '0;
    end else if (vld_q[L-2]) begin
      out_pix_q  <= pix_d;
      out_orig_q <= win_q[1][1];
    end
  end

  assign out_valid  = vld_q[L-1];
  assign out_sof    = sof_q[L-1];
  assign out_border = bd_q[L-1];
  assign out_pix    = out_pix_q;
  assign out_orig   = out_orig_q;

endmodule

// File: tb/tb_sobel_stream_param.sv
// Directed bench for sobel_stream_param on a 12x6 frame.
// Expected pixels come from a direct 3x3 window model.
module tb_sobel_stream_param;

  localparam int W  = 12;
  localparam int H  = 6;
  localparam int SH = 0;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, in_sof;
  logic [7:0] in_pix, thresh;
  logic [2:0] mode;
  logic       out_valid, out_sof, out_border;
  logic [7:0] out_pix, out_orig;

  always #5 clk = ~clk;

  sobel_stream_param #(
    .IMG_W(W), .IMG_H(H), .PIX_W(8), .MAG_SHIFT(SH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .in_pix     (in_pix),
    .mode       (mode),
    .thresh     (thresh),
    .out_valid  (out_valid),
    .out_sof    (out_sof),
    .out_pix    (out_pix),
    .out_orig   (out_orig),
    .out_border (out_border)
  );

  typedef struct {
    int due;
    int pix;
    int orig;
    bit bd;
    bit sof;
    bit ck_pix;
    bit ck_orig;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   ff_cnt = 0;
  int   img [H][W];
  int   mx, my, m_mode, m_thr;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)",
               tag, obs, exp, cyc);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  function automatic int pixf(input int k, input int x, input int y);
    if (k == 0) return 'h80;
    if (k == 1) return (x < 8) ? 0 : 'hFF;
    return (x * 37 + y * 91 + 13) & 'hFF;
  endfunction

  task automatic model_push(input logic [7:0] p, input bit sof);
    exp_t e;
    int gx, gy, ax, ay, mg, mc, o;
    if (sof) begin
      mx = 0; my = 0;
      m_mode = int'(mode);
      m_thr = int'(thresh);
    end
    img[my][mx] = int'(p);
    e.due = cyc + 4;
    e.sof = sof;
    e.bd = (mx < 2) || (my < 2);
    e.ck_orig = !e.bd;
    e.ck_pix = !(e.bd && m_mode == 4);
    e.pix = 0;
    e.orig = 0;
    if (!e.bd) begin
      gx = img[my-2][mx] + 2*img[my-1][mx] + img[my][mx]
         - img[my-2][mx-2] - 2*img[my-1][mx-2] - img[my][mx-2];
      gy = img[my-2][mx-2] + 2*img[my-2][mx-1] + img[my-2][mx]
         - img[my][mx-2] - 2*img[my][mx-1] - img[my][mx];
      ax = (gx < 0) ? -gx : gx;
      ay = (gy < 0) ? -gy : gy;
      mg = (ax + ay) >> SH;
      mc = sat(mg);
      o = img[my-1][mx-1];
      e.orig = o;
      case (m_mode)
        1: e.pix = sat(ax);
        2: e.pix = sat(ay);
        3: e.pix = (mg >= m_thr) ? 255 : 0;
        4: e.pix = o;
        5: e.pix = (o > mc) ? o : mc;
        default: e.pix = mc;
      endcase
    end
    q.push_back(e);
    if (mx == W-1) begin
      mx = 0;
      my = (my == H-1) ? 0 : my + 1;
    end else begin
      mx = mx + 1;
    end
  endtask

  task automatic drive(input bit v, input bit sof, input logic [7:0] p);
    @(negedge clk);
    in_valid = v;
    in_sof = sof;
    in_pix = p;
    if (v) model_push(p, sof);
  endtask

  task automatic send(input int kind, input int n,
                      input bit sof1, input int gap);
    int sx, sy;
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < 3 && gap > 0
           && $urandom_range(99) < gap; g++)
        drive(1'b0, 1'($urandom_range(1)), 8'($urandom));
      sx = (sof1 && i == 0) ? 0 : mx;
      sy = (sof1 && i == 0) ? 0 : my;
      drive(1'b1, sof1 && i == 0, 8'(pixf(kind, sx, sy)));
    end
    drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic drain;
    repeat (8) drive(1'b0, 1'b0, 8'h00);
    chk("drain_empty", q.size(), 0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // compare every result against the head of the expectation queue
  always @(posedge clk) begin
    #1;
    if (out_valid) begin
      chk("expected_beat", q.size() != 0, 1);
      if (q.size() != 0) begin
        mon_e = q.pop_front();
        chk("latency", cyc, mon_e.due);
        chk("border", out_border, mon_e.bd);
        chk("sof", out_sof, mon_e.sof);
        if (mon_e.ck_pix) chk("pix", out_pix, mon_e.pix);
        if (mon_e.ck_orig) chk("orig", out_orig, mon_e.orig);
      end
      if (out_pix == 8'hFF) ff_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
    in_pix = 8'h00; mode = 3'd0; thresh = 8'h00;
    mx = 0; my = 0; m_mode = 0; m_thr = 0;
    repeat (3) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_pix", out_pix, 0);
    chk("rst_orig", out_orig, 0);
    chk("rst_border", out_border, 0);
    chk("rst_sof", out_sof, 0);
    rst_n = 1'b1;

    // T1 flat frame, MAG
    mode = 3'd0;
    send(0, W*H, 1'b1, 0);
    drain();

    // T2 vertical step, MAG: two saturated columns per interior row
    ff_cnt = 0;
    send(1, W*H, 1'b1, 0);
    drain();
    chk("t2_edge_count", ff_cnt, 2*(H-2));

    // T3 same step, THRESH 0x40 then GY_ABS
    mode = 3'd3; thresh = 8'h40; ff_cnt = 0;
    send(1, W*H, 1'b1, 0);
    drain();
    chk("t3_thresh_count", ff_cnt, 2*(H-2));
    mode = 3'd2; ff_cnt = 0;
    send(1, W*H, 1'b1, 0);
    drain();
    chk("t3_gy_count", ff_cnt, 0);

    // extra modes on the textured frame
    mode = 3'd1; send(2, W*H, 1'b1, 0); drain();
    mode = 3'd5; send(2, W*H, 1'b1, 0); drain();
    mode = 3'd7; send(2, W*H, 1'b1, 0); drain();

    // T4 random idle gaps, stray in_sof while idle
    mode = 3'd0;
    send(2, W*H, 1'b1, 30);
    drain();

    // T5 mid-frame mode change, then mid-line restart
    mode = 3'd0;
    send(2, 30, 1'b1, 0);
    mode = 3'd4;
    send(2, 10, 1'b0, 0);
    send(2, W*H, 1'b1, 0);
    drain();

    // T6 one-cycle reset mid-line with a dropped beat
    mode = 3'd0;
    send(2, 15, 1'b1, 0);
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b1; in_sof = 1'b0; in_pix = 8'h55;
    q.delete();
    @(posedge clk);
    #2;
    chk("t6_valid", out_valid, 0);
    chk("t6_pix", out_pix, 0);
    chk("t6_orig", out_orig, 0);
    chk("t6_border", out_border, 0);
    chk("t6_sof", out_sof, 0);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    mx = 0; my = 0; m_mode = 0; m_thr = 0;
    mode = 3'd4; thresh = 8'h10;
    send(2, W*H, 1'b0, 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
